// File: rtl/axi_ram_responder_if.sv
// AXI4 bus bundle for the RAM responder: AW/W/B/AR/R channels with master and slave views.
interface axi_ram_responder_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
   parameter int unsigned ID_WIDTH   = 8
);
   logic [ID_WIDTH-1:0]   awid;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [7:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;
   logic                  awlock;
   logic [3:0]            awcache;
   logic [2:0]            awprot;
   logic                  awvalid;
   logic                  awready;

   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wlast;
   logic                  wvalid;
   logic                  wready;

   logic [ID_WIDTH-1:0]   bid;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;

   logic [ID_WIDTH-1:0]   arid;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [7:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic                  arlock;
   logic [3:0]            arcache;
   logic [2:0]            arprot;
   logic                  arvalid;
   logic                  arready;

   logic [ID_WIDTH-1:0]   rid;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/axi_ram_responder.sv
// AXI4 slave terminating in a word-addressed RAM; independent write and read burst engines
// with FIXED/INCR/WRAP addressing, byte strobes and a one-deep prefetching read stage.
module axi_ram_responder #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
   parameter int unsigned ID_WIDTH   = 8
) (
   input logic              clk,
   input logic              rst_n,
   axi_ram_responder_if.slave s_axi
);
   localparam int unsigned OffW  = $clog2(STRB_WIDTH);
   localparam int unsigned IdxW  = ADDR_WIDTH - OffW;
   localparam int unsigned Depth = 2 ** IdxW;

   typedef logic [ADDR_WIDTH-1:0] addr_t;

   function automatic addr_t next_addr(addr_t addr, logic [7:0] len, logic [2:0] size,
                                       logic [1:0] burst);
      logic [2:0] eff;
      addr_t      incr;
      addr_t      mask;
      addr_t      res;
      eff  = (size > 3'(OffW)) ? 3'(OffW) : size;
      incr = addr + (addr_t'(1) << eff);
      mask = ((addr_t'(len) + addr_t'(1)) << eff) - addr_t'(1);
      case (burst)
         2'b00:   res = addr;
         2'b10:   res = (addr & ~mask) | (incr & mask);
         default: res = incr;
      endcase
      return res;
   endfunction

   logic [DATA_WIDTH-1:0] mem [Depth];

   // Sideband attributes carry no meaning for a plain RAM target.
   logic unused_sideband;
   assign unused_sideband = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.wlast,
                              s_axi.arlock, s_axi.arcache, s_axi.arprot};

   // ---------------- write engine ----------------
   typedef enum logic [1:0] {WInit, WIdle, WData, WResp} w_state_e;

   w_state_e              w_state_q, w_state_d;
   logic [ID_WIDTH-1:0]   wid_q, wid_d;
   addr_t                 waddr_q, waddr_d;
   logic [7:0]            wlen_q, wlen_d;
   logic [2:0]            wsize_q, wsize_d;
   logic [1:0]            wburst_q, wburst_d;
   logic [7:0]            wcnt_q, wcnt_d;
   logic                  w_hs;
   logic [IdxW-1:0]       widx;

   assign w_hs = (w_state_q == WData) && s_axi.wvalid;
   assign widx = waddr_q[ADDR_WIDTH-1:OffW];

   always_comb begin
      w_state_d = w_state_q;
      wid_d     = wid_q;
      waddr_d   = waddr_q;
      wlen_d    = wlen_q;
      wsize_d   = wsize_q;
      wburst_d  = wburst_q;
      wcnt_d    = wcnt_q;
      unique case (w_state_q)
         WInit: w_state_d = WIdle;
         WIdle: begin
            if (s_axi.awvalid) begin
               wid_d     = s_axi.awid;
               waddr_d   = s_axi.awaddr;
               wlen_d    = s_axi.awlen;
               wsize_d   = s_axi.awsize;
               wburst_d  = s_axi.awburst;
               wcnt_d    = 8'd0;
               w_state_d = WData;
            end
         end
         WData: begin
            if (s_axi.wvalid) begin
               waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
               wcnt_d  = wcnt_q + 8'd1;
               if (wcnt_q == wlen_q) w_state_d = WResp;
            end
         end
         WResp: if (s_axi.bready) w_state_d = WIdle;
         default: w_state_d = WIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state_q <= WInit;
         wid_q     <= '0;
         waddr_q   <= '0;
         wlen_q    <= '0;
         wsize_q   <= '0;
         wburst_q  <= '0;
         wcnt_q    <= '0;
      end else begin
         w_state_q <= w_state_d;
         wid_q     <= wid_d;
         waddr_q   <= waddr_d;
         wlen_q    <= wlen_d;
         wsize_q   <= wsize_d;
         wburst_q  <= wburst_d;
         wcnt_q    <= wcnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_hs) begin
         for (int b = 0; b < int'(STRB_WIDTH); b++) begin
            if (s_axi.wstrb[b]) mem[widx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
         end
      end
   end

   assign s_axi.awready = (w_state_q == WIdle);
   assign s_axi.wready  = (w_state_q == WData);
   assign s_axi.bvalid  = (w_state_q == WResp);
   assign s_axi.bid     = wid_q;
   assign s_axi.bresp   = 2'b00;

   // ---------------- read engine ----------------
   typedef enum logic [1:0] {RInit, RIdle, RData} r_state_e;

   r_state_e              r_state_q, r_state_d;
   logic [ID_WIDTH-1:0]   rid_q, rid_d;
   addr_t                 raddr_q, raddr_d;
   logic [7:0]            rlen_q, rlen_d;
   logic [2:0]            rsize_q, rsize_d;
   logic [1:0]            rburst_q, rburst_d;
   logic [8:0]            rcnt_q, rcnt_d;
   logic                  rvalid_q, rvalid_d;
   logic                  rlast_q, rlast_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [IdxW-1:0]       ridx;

   assign ridx = raddr_q[ADDR_WIDTH-1:OffW];

   always_comb begin
      r_state_d = r_state_q;
      rid_d     = rid_q;
      raddr_d   = raddr_q;
      rlen_d    = rlen_q;
      rsize_d   = rsize_q;
      rburst_d  = rburst_q;
      rcnt_d    = rcnt_q;
      rvalid_d  = rvalid_q;
      rlast_d   = rlast_q;
      rdata_d   = rdata_q;
      unique case (r_state_q)
         RInit: r_state_d = RIdle;
         RIdle: begin
            if (s_axi.arvalid) begin
               rid_d     = s_axi.arid;
               raddr_d   = s_axi.araddr;
               rlen_d    = s_axi.arlen;
               rsize_d   = s_axi.arsize;
               rburst_d  = s_axi.arburst;
               rcnt_d    = 9'd0;
               r_state_d = RData;
            end
         end
         RData: begin
            if (rvalid_q && s_axi.rready) begin
               rvalid_d = 1'b0;
               rlast_d  = 1'b0;
               if (rlast_q) r_state_d = RIdle;
            end
            // Refill the output stage as it drains; rcnt counts beats already fetched.
            if ((!rvalid_q || s_axi.rready) && (rcnt_q != 9'(rlen_q) + 9'd1)) begin
               rvalid_d = 1'b1;
               rlast_d  = (rcnt_q == 9'(rlen_q));
               rdata_d  = mem[ridx];
               raddr_d  = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
               rcnt_d   = rcnt_q + 9'd1;
            end
         end
         default: r_state_d = RIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state_q <= RInit;
         rid_q     <= '0;
         raddr_q   <= '0;
         rlen_q    <= '0;
         rsize_q   <= '0;
         rburst_q  <= '0;
         rcnt_q    <= '0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rdata_q   <= '0;
      end else begin
         r_state_q <= r_state_d;
         rid_q     <= rid_d;
         raddr_q   <= raddr_d;
         rlen_q    <= rlen_d;
         rsize_q   <= rsize_d;
         rburst_q  <= rburst_d;
         rcnt_q    <= rcnt_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
         rdata_q   <= rdata_d;
      end
   end

   assign s_axi.arready = (r_state_q == RIdle);
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rlast   = rlast_q;
   assign s_axi.rdata   = rdata_q;
   assign s_axi.rid     = rid_q;
   assign s_axi.rresp   = 2'b00;
endmodule

// File: doc/axi_ram_responder.md
# axi_ram_responder

AXI4 slave endpoint that terminates a full AXI4 master port, such as the single master output of the interconnect, in an on-chip word-addressed RAM. Independent write and read engines support FIXED, INCR and WRAP bursts of 1–256 beats. Narrow transfers and byte strobes are supported. Reads sustain one beat per cycle after the initial latency. The block is used as a memory target in the SoC and as the standard responder model in interconnect benches.

## Interface
- DATA_WIDTH, 32, data bus width in bits (8·2^n).
- ADDR_WIDTH, 16, byte address width; memory depth is 2^ADDR_WIDTH/STRB_WIDTH words.
- STRB_WIDTH, DATA_WIDTH/8, byte-strobe width.
- ID_WIDTH, 8, transaction ID width.
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_axi_aw{id,addr,len,size,burst,lock,cache,prot}, s_axi_awvalid  in  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3/1  write address; lock/cache/prot ignored.
- s_axi_awready  out  1.
- s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid  in  DATA_WIDTH/STRB_WIDTH/1/1  write data.
- s_axi_wready  out  1.
- s_axi_bid, s_axi_bresp, s_axi_bvalid  out  ID_WIDTH/2/1; s_axi_bready  in  1.
- s_axi_ar{id,addr,len,size,burst,lock,cache,prot}, s_axi_arvalid  in  same widths as AW; s_axi_arready  out  1.
- s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid  out  ID_WIDTH/DATA_WIDTH/2/1/1; s_axi_rready  in  1.

## Operation
- Word index = addr[ADDR_WIDTH-1:log2(STRB_WIDTH)]. Upper address bits beyond ADDR_WIDTH do not exist; the index wraps modulo the depth.
- Address step per beat:
  - FIXED: unchanged.
  - INCR and reserved 2'b11: addr + (1<<size).
  - WRAP: (addr & ~M) | ((addr + (1<<size)) & M), with M = ((len+1)<<size) − 1.
  - A size greater than log2(STRB_WIDTH) is treated as log2(STRB_WIDTH).
- Beat count = len+1. wlast is ignored; the beat counter alone ends a write burst.
- Write FSM:
  - W_IDLE (awready=1): on AW handshake, capture id/addr/len/size/burst → W_DATA.
  - W_DATA (wready=1): on each W handshake, write the bytes whose wstrb bit is 1 to the current word, then step the address. After the final beat → W_RESP.
  - W_RESP (bvalid=1, bid=captured id, bresp=2'b00): on B handshake → W_IDLE.
- Read FSM:
  - R_IDLE (arready=1): on AR handshake, capture fields → R_DATA.
  - R_DATA: the memory read is issued ahead of time through a single output stage. A new word is read whenever the stage is empty or is being drained (rvalid=0 or rready=1) and beats remain.
  - rid=captured id, rresp=2'b00, rlast=1 on beat len+1. After the rlast handshake → R_IDLE.
- Read and write engines are fully independent and may be active at the same time.
- Same-word collision: a read and a write to the same word on the same edge return the old data (read-first).
- rdata holds its value while rvalid=1 and rready=0.
- Responses are always OKAY; the block never returns SLVERR/DECERR.
- Memory contents are not reset.

## Timing
- While rst_n=0: awready, wready, bvalid, arready, rvalid, rlast = 0; bid, bresp, rid, rresp, rdata = 0.
- awready and arready rise on the first edge after rst_n deasserts.
- Asserting rst_n mid-burst aborts both engines immediately. No B or R response is produced for the aborted transaction.
- Write timing:
  - AW handshake at edge E → wready=1 after E. W beats before the AW handshake are not accepted.
  - Last W handshake at edge E → wready=0 and bvalid=1 after E.
  - B handshake at E → awready=1 after E.
  - Single-beat write with bready=1: AW at E0, W at E1, B at E2, next AW accepted at E3.
- Read timing:
  - AR handshake at E0 → first rvalid=1 after E1.
  - With rready held at 1, beats arrive on consecutive cycles; a burst of len L completes at E1+L+1.
  - rlast handshake at E → arready=1 after E. Back-to-back read bursts therefore have a 2-cycle bubble.
- Stall: rready=0 holds rvalid, rdata, rlast and rid stable. No memory read is issued until the stage drains.

## Test plan
- Single write then read:
  - Stimulus: AW addr 0x0010, len 0, size 2, id 0x3A, wdata 0xDEADBEEF, wstrb 0xF; then AR to the same address.
  - Required: bid 0x3A, bresp 0; rdata 0xDEADBEEF, rlast=1, rid 0x3A, first rvalid two edges after AR.
- Byte strobes:
  - Stimulus: word 0x0 preloaded with 0x11223344; write 0xAABBCCDD with wstrb 0x5; read back.
  - Required: 0x11BB33DD.
- INCR burst with backpressure:
  - Stimulus: write 8 beats (values 1..8) at 0x0100; read len 7 with rready toggling 1,0,1,0….
  - Required: data 1..8 in order, stable during stalls, rlast only on beat 8.
- WRAP and FIXED bursts:
  - Stimulus: WRAP len 3, size 2, start 0x0108.
  - Required: addresses 0x108, 0x10C, 0x100, 0x104.
  - Stimulus: FIXED len 3 writing 1,2,3,4 to 0x0200.
  - Required: the word reads back 4.
- Concurrency and collision:
  - Stimulus: read and write bursts in flight simultaneously to disjoint regions, plus one same-edge read/write to word 0x0300 (old 0x0, new 0x5).
  - Required: both bursts complete correctly; the colliding read returns 0x0.
- Reset mid-burst:
  - Stimulus: drop rst_n during beat 3 of a len 7 read and during beat 2 of a write.
  - Required: all valid/ready outputs go to 0 immediately; after release, awready and arready return and a new transaction completes normally.
